// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO fabric.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_READDATA = 32'h0;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } state_e;

  // Slave-select field width; never zero so a single-slave build still decodes.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/mmio_fabric_if.sv
// CPU-side request/response and slave-bank signals of the MMIO fabric.
// slave: the fabric's view; master: the CPU and slave bank that surround it.
interface mmio_fabric_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 12
);
  import mmio_pkg::*;

  logic                         cpu_read;
  logic                         cpu_write;
  logic [ADDR_W-1:0]            cpu_address;
  logic [DATA_W-1:0]            cpu_writedata;
  logic [BE_W-1:0]              cpu_byte_enable;
  logic [DATA_W-1:0]            cpu_readdata;
  logic                         cpu_ready;
  logic                         cpu_error;

  logic [NUM_SLAVES-1:0]        slv_read;
  logic [NUM_SLAVES-1:0]        slv_write;
  logic [ADDR_W-1:0]            slv_address;
  logic [DATA_W-1:0]            slv_writedata;
  logic [BE_W-1:0]              slv_byte_enable;
  logic [NUM_SLAVES*DATA_W-1:0] slv_readdata;
  logic [NUM_SLAVES-1:0]        slv_ready;

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byte_enable,
    output cpu_readdata, cpu_ready, cpu_error,
    output slv_read, slv_write, slv_address, slv_writedata, slv_byte_enable,
    input  slv_readdata, slv_ready
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_writedata, cpu_byte_enable,
    input  cpu_readdata, cpu_ready, cpu_error,
    input  slv_read, slv_write, slv_address, slv_writedata, slv_byte_enable,
    output slv_readdata, slv_ready
  );

endinterface

// File: rtl/mmio_decode.sv
// Splits a CPU word address into slave index, mapped flag and in-slave offset.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 12,
  localparam int unsigned SEL_W     = sel_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              mapped_o,
  output logic [ADDR_W-1:0] offset_o
);

  assign idx_o    = addr_i[ADDR_W-1 -: SEL_W];
  assign mapped_o = (32'(idx_o) < NUM_SLAVES);

  always_comb begin
    offset_o = addr_i;
    offset_o[ADDR_W-1 -: SEL_W] = '0;
  end

endmodule

// File: rtl/mmio_fabric.sv
// Single-outstanding MMIO fabric: one CPU port fanned out to NUM_SLAVES slaves.
// Optional access timeout is compiled in with MMIO_FABRIC_TIMEOUT_EN.
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  mmio_fabric_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NUM_SLAVES);

  state_e              state_q, state_d;
  logic                op_write_q, op_write_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    dec_idx;
  logic                dec_mapped;
  logic [ADDR_W-1:0]   dec_offset;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

`ifdef MMIO_FABRIC_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  logic                unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  mmio_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W)
  ) u_decode (
    .addr_i   (bus.cpu_address),
    .idx_o    (dec_idx),
    .mapped_o (dec_mapped),
    .offset_o (dec_offset)
  );

  // Only the addressed slave's ready/data is observed; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_ready = bus.slv_ready[i];
        sel_rdata = bus.slv_readdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef MMIO_FABRIC_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_read || bus.cpu_write) begin
          op_write_d = bus.cpu_write;
          idx_d      = dec_idx;
          addr_d     = dec_offset;
          wdata_d    = bus.cpu_writedata;
          be_d       = bus.cpu_byte_enable;
`ifdef MMIO_FABRIC_TIMEOUT_EN
          cnt_d      = '0;
`endif
          if (dec_mapped) begin
            state_d = StAccess;
            err_d   = 1'b0;
          end else begin
            state_d = StRespond;
            err_d   = 1'b1;
            rdata_d = ERR_READDATA;
          end
        end
      end
      StAccess: begin
`ifdef MMIO_FABRIC_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (sel_ready) begin
          state_d = StRespond;
          err_d   = 1'b0;
          rdata_d = op_write_q ? '0 : sel_rdata;
        end
`ifdef MMIO_FABRIC_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = StRespond;
          err_d   = 1'b1;
          rdata_d = ERR_READDATA;
        end
`endif
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef MMIO_FABRIC_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef MMIO_FABRIC_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    bus.slv_read  = '0;
    bus.slv_write = '0;
    if (state_q == StAccess) begin
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
        if (idx_q == SEL_W'(i)) begin
          bus.slv_write[i] = op_write_q;
          bus.slv_read[i]  = !op_write_q;
        end
      end
    end
  end

  assign bus.cpu_ready       = (state_q == StRespond);
  assign bus.cpu_error       = (state_q == StRespond) && err_q;
  assign bus.cpu_readdata    = rdata_q;
  assign bus.slv_address     = addr_q;
  assign bus.slv_writedata   = wdata_q;
  assign bus.slv_byte_enable = be_q;

endmodule
